seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 172 +++++++++++++++++
 tb/tb_seq_divider.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle 32-bit integer divider, signed or unsigned. It runs one
// restoring step per clock: 32 steps, then one cycle to apply the result
// signs. With an accept at edge E0, done is high in the cycle after E0+33.
// A zero divisor skips the iterations and reports after a single edge.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset, sampled on rising clk
//   start      request a division; accepted only in IDLE
//   sgn        1 = two's-complement operands, 0 = unsigned (sampled with start)
//   dividend   numerator (sampled with start)
//   divisor    denominator (sampled with start)
//   busy       high from the accept edge until done rises
//   done       one-cycle pulse; quotient, remainder and dbz are valid
//   quotient   result quotient, held until the next result
//   remainder  result remainder, held until the next result
//   dbz        divide-by-zero flag, held with the results
// -----------------------------------------------------------------------------
module seq_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        dbz
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q,     state_d;
    logic [5:0]  cnt_q,       cnt_d;
    logic [32:0] rem_q,       rem_d;        // partial remainder R
    logic [31:0] quo_q,       quo_d;        // quotient shift register Q
    logic [31:0] dmag_q,      dmag_d;       // |divisor|
    logic        q_neg_q,     q_neg_d;
    logic        r_neg_q,     r_neg_d;
    logic [31:0] quotient_q,  quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        dbz_q,       dbz_d;

    // Operand magnitudes. 0x80000000 negates to itself, which is the correct
    // unsigned magnitude, so no special case is needed.
    logic        dvd_neg;
    logic        dvs_neg;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;

    assign dvd_neg = sgn & dividend[31];
    assign dvs_neg = sgn & divisor[31];
    assign dvd_mag = dvd_neg ? (~dividend + 32'd1) : dividend;
    assign dvs_mag = dvs_neg ? (~divisor + 32'd1) : divisor;

    // Trial subtraction on the left-shifted {R,Q}. R stays below |divisor|,
    // so the shifted value fits in 33 bits and bit 33 of the difference is
    // a clean borrow/sign flag.
    logic [33:0] trial;
    assign trial = {rem_q, quo_q[31]} - {2'b00, dmag_q};

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dmag_d      = dmag_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_neg_d = dvd_neg ^ dvs_neg;
                    r_neg_d = dvd_neg;
                    dmag_d  = dvs_mag;
                    rem_d   = 33'd0;
                    quo_d   = dvd_mag;
                    cnt_d   = 6'd32;
                    if (divisor == 32'd0) begin
                        // Results are final immediately; the raw dividend is
                        // returned, not its magnitude.
                        quotient_d  = 32'hFFFF_FFFF;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                if (trial[33]) begin
                    rem_d = {rem_q[31:0], quo_q[31]};   // restore
                    quo_d = {quo_q[30:0], 1'b0};
                end else begin
                    rem_d = trial[32:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                quotient_d  = q_neg_q ? (~quo_q + 32'd1) : quo_q;
                remainder_d = r_neg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
                dbz_d       = 1'b0;
                state_d     = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: reset is tested inside the clocked block, so it takes effect only on a rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 6'd0;
            rem_q       <= 33'd0;
            quo_q       <= 32'd0;
            dmag_q      <= 32'd0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            dbz_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples its pre-edge _d value.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dmag_q      <= dmag_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Status is a pure decode of the state register, so it is glitch-free
    // and lines up exactly with the state transitions.
    assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
    assign done      = (state_q == S_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Directed self-checking bench for seq_divider. Each vector carries hand-
// computed quotient, remainder, dbz and latency. Latency is counted in
// rising edges from the accept edge (inclusive) to the edge that raises
// done: 34 for a normal divide, 1 for a zero divisor.
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sgn;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        dbz;

    int n_vec = 0;
    int n_err = 0;

    seq_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sgn       (sgn),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Waits for done with a bound; edges is the running edge count since
    // (and including) the accept edge. Call #1 after a rising edge.
    task automatic wait_done(inout int edges);
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic run_div(input string tag, input logic s,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic ed, input int elat);
        int edges;
        @(negedge clk);
        start    = 1'b1;
        sgn      = s;
        dividend = a;
        divisor  = b;
        @(posedge clk);               // accept edge E0
        #1;
        start = 1'b0;
        edges = 1;
        wait_done(edges);
        check({tag, " latency"},   32'(edges), 32'(elat));
        check({tag, " quotient"},  quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " dbz"},       {31'd0, dbz}, {31'd0, ed});
        check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int  edges;
        logic seen_done;

        rst_n    = 1'b0;
        start    = 1'b0;
        sgn      = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst busy",      {31'd0, busy}, 32'd0);
        check("rst done",      {31'd0, done}, 32'd0);
        check("rst dbz",       {31'd0, dbz},  32'd0);
        check("rst quotient",  quotient,  32'd0);
        check("rst remainder", remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- basic, signed, dbz, extremes ----
        run_div("u 100/7",     1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34);
        run_div("s -100/7",    1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 34);
        run_div("s 100/-7",    1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 34);
        run_div("s -100/-7",   1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 34);
        run_div("s 5/0",       1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1);
        run_div("s -7/2",      1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34);
        run_div("u dbz raw",   1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1);
        run_div("s ovf",       1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34);
        run_div("u max/1",     1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 34);
        run_div("u 3/max",     1'b0, 32'd3,          32'hFFFF_FFFF,  32'd0,          32'd3,          1'b0, 34);
        run_div("u max/16",    1'b0, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  32'd15,         1'b0, 34);

        // ---- start held high across a whole operation ----
        @(negedge clk);
        start    = 1'b1;
        sgn      = 1'b0;
        dividend = 32'd50;
        divisor  = 32'd6;
        @(posedge clk);
        #1;
        edges = 1;
        check("hold busy@accept", {31'd0, busy}, 32'd1);
        wait_done(edges);
        check("hold latency",   32'(edges), 32'd34);
        check("hold quotient",  quotient,  32'd8);
        check("hold remainder", remainder, 32'd2);
        @(posedge clk);
        #1;
        check("hold idle done", {31'd0, done}, 32'd0);
        check("hold idle busy", {31'd0, busy}, 32'd0);
        @(posedge clk);               // IDLE with start still high: re-accept
        #1;
        check("hold reaccept", {31'd0, busy}, 32'd1);
        start    = 1'b0;
        dividend = 32'd99;            // must not disturb the latched operands
        edges    = 1;
        wait_done(edges);
        check("hold2 latency",   32'(edges), 32'd34);
        check("hold2 quotient",  quotient,  32'd8);
        check("hold2 remainder", remainder, 32'd2);
        @(posedge clk);
        #1;

        // ---- start pulsed mid-CALC with new operands ----
        @(negedge clk);
        start    = 1'b1;
        sgn      = 1'b0;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        repeat (5) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("mid held quotient", quotient, 32'd8);
        @(negedge clk);
        start    = 1'b1;
        sgn      = 1'b1;
        dividend = 32'd7;
        divisor  = 32'd0;
        @(posedge clk);
        #1;
        edges++;
        start = 1'b0;
        check("mid busy", {31'd0, busy}, 32'd1);
        check("mid dbz",  {31'd0, dbz},  32'd0);
        wait_done(edges);
        check("mid latency",   32'(edges), 32'd34);
        check("mid quotient",  quotient,  32'd333);
        check("mid remainder", remainder, 32'd1);
        check("mid dbz@done",  {31'd0, dbz}, 32'd0);
        @(posedge clk);
        #1;

        // ---- reset during CALC step 10 ----
        @(negedge clk);
        start    = 1'b1;
        sgn      = 1'b0;
        dividend = 32'd200;
        divisor  = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);    // CALC steps 1..9 done
        @(negedge clk);
        rst_n    = 1'b0;
        start    = 1'b1;              // must be ignored while in reset
        dividend = 32'd4;
        divisor  = 32'd0;
        @(posedge clk);
        #1;
        check("midrst busy",      {31'd0, busy}, 32'd0);
        check("midrst done",      {31'd0, done}, 32'd0);
        check("midrst dbz",       {31'd0, dbz},  32'd0);
        check("midrst quotient",  quotient,  32'd0);
        check("midrst remainder", remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done = 1'b1;
        end
        check("midrst no activity", {31'd0, seen_done}, 32'd0);
        run_div("post-rst 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
